dataflow_mc: RTL and testbench

//  Single-clock, parametrised multi-cycle RV32I datapath with an internal phase sequencer.

---
 rtl/dataflow_mc.sv | 184 ++++++++++++++++++
 tb/tb_dataflow_mc.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dataflow_mc.sv
// dataflow_mc: single-clock multi-cycle RV32I datapath with an internal phase sequencer.
// The PC, instruction register and register file are enables driven by a four-phase FSM.
// Every fetch and data access uses a mem_req/mem_ready handshake, so memory may insert
// wait states. An external combinational decoder reads insn_out and EQ/LS/LU and drives
// the control inputs.
//
// Ports
//   clk, reset_n          single rising-edge clock, asynchronous active-low reset
//   mem_req/we/addr/wdata memory request (held until mem_ready), store data is raw rs2
//   mem_rdata, mem_ready  read data and request completion
//   insn_out              instruction register, to the decoder
//   rs1, rs2, rd, imm,
//   func, sub_sra,
//   alu_sel_a/b,
//   pc_alu_sel,
//   pc_next_sel, rd_sel,
//   rd_we, is_load,
//   is_store, mem_size    decoded controls
//   EQ, LS, LU            ALU operand compares: equal, signed less, unsigned less
//   retire                one-cycle pulse in write-back
//   dbg_raddr/dbg_rdata   combinational debug register read
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_FETCH | request instruction at pc, wait for mem_ready, load insn
// S_EXEC  | one cycle for the decoder and ALU to settle
// S_MEM   | load/store at alu_val, wait for mem_ready, capture mdr on load
// S_WB    | update pc and rd, pulse retire
module dataflow_mc #(
   parameter int               XLEN     = 32,
   parameter int               NREGS    = 32,
   parameter logic [XLEN-1:0]  RESET_PC = '0,
   parameter int               PC_STEP  = 4,
   localparam int              RW       = $clog2(NREGS)
) (
   input  logic            clk,
   input  logic            reset_n,
   output logic            mem_req,
   output logic            mem_we,
   output logic [XLEN-1:0] mem_addr,
   output logic [XLEN-1:0] mem_wdata,
   input  logic [XLEN-1:0] mem_rdata,
   input  logic            mem_ready,
   output logic [XLEN-1:0] insn_out,
   input  logic [RW-1:0]   rs1,
   input  logic [RW-1:0]   rs2,
   input  logic [RW-1:0]   rd,
   input  logic [XLEN-1:0] imm,
   input  logic [2:0]      func,
   input  logic            sub_sra,
   input  logic            alu_sel_a,
   input  logic            alu_sel_b,
   input  logic            pc_alu_sel,
   input  logic            pc_next_sel,
   input  logic [1:0]      rd_sel,
   input  logic            rd_we,
   input  logic            is_load,
   input  logic            is_store,
   input  logic [2:0]      mem_size,
   output logic            EQ,
   output logic            LS,
   output logic            LU,
   output logic            retire,
   input  logic [RW-1:0]   dbg_raddr,
   output logic [XLEN-1:0] dbg_rdata
);

   localparam int              SW         = $clog2(XLEN);
   localparam logic [XLEN-1:0] PC_STEP_X  = XLEN'(PC_STEP);

   typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM, S_WB} state_t;

   state_t            state;
   logic [XLEN-1:0]   pc;
   logic [XLEN-1:0]   insn;
   logic [XLEN-1:0]   mdr;
   logic [1:0]        byte_off;
   logic [XLEN-1:0]   regs [NREGS];

   logic [XLEN-1:0]   rs1_val, rs2_val, alu_a, alu_b, alu_val;
   logic signed [XLEN-1:0] sra_val;
   logic [SW-1:0]     shamt;
   logic [XLEN-1:0]   pc_inc, pc_next, mem_ext, rd_val;
   logic [15:0]       lane;

   assign rs1_val = (rs1 == '0) ? '0 : regs[rs1];
   assign rs2_val = (rs2 == '0) ? '0 : regs[rs2];
   assign alu_a   = alu_sel_a ? pc  : rs1_val;
   assign alu_b   = alu_sel_b ? imm : rs2_val;
   assign shamt   = alu_b[SW-1:0];
   assign sra_val = $signed(alu_a) >>> shamt;

   assign EQ = (alu_a == alu_b);
   assign LS = ($signed(alu_a) < $signed(alu_b));
   assign LU = (alu_a < alu_b);

   always_comb begin
      alu_val = '0;
      case (func)
         3'b000:  alu_val = sub_sra ? (alu_a - alu_b) : (alu_a + alu_b);
         3'b001:  alu_val = alu_a << shamt;
         3'b010:  alu_val = {{(XLEN-1){1'b0}}, LS};
         3'b011:  alu_val = {{(XLEN-1){1'b0}}, LU};
         3'b100:  alu_val = alu_a ^ alu_b;
         3'b101:  alu_val = sub_sra ? sra_val : (alu_a >> shamt);
         3'b110:  alu_val = alu_a | alu_b;
         default: alu_val = alu_a & alu_b;
      endcase
   end

   assign pc_inc  = pc + (pc_alu_sel ? imm : PC_STEP_X);
   assign pc_next = pc_next_sel ? {alu_val[XLEN-1:1], 1'b0} : pc_inc;

   // Halfword lane starting at the latched byte offset; at offset 3 the upper byte is zero.
   assign lane = 16'(mdr >> {byte_off, 3'b000});

   always_comb begin
      mem_ext = mdr;
      case (mem_size)
         3'b000:  mem_ext = {{(XLEN-8){lane[7]}}, lane[7:0]};
         3'b001:  mem_ext = {{(XLEN-16){lane[15]}}, lane};
         3'b100:  mem_ext = {{(XLEN-8){1'b0}}, lane[7:0]};
         3'b101:  mem_ext = {{(XLEN-16){1'b0}}, lane};
         default: mem_ext = mdr;
      endcase
   end

   always_comb begin
      rd_val = '0;
      case (rd_sel)
         2'b00:   rd_val = mem_ext;
         2'b01:   rd_val = imm;
         2'b10:   rd_val = alu_val;
         default: rd_val = pc_inc;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= S_FETCH;
         pc       <= RESET_PC;
         insn     <= '0;
         mdr      <= '0;
         byte_off <= '0;
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      end else begin
         case (state)
            S_FETCH: begin
               if (mem_ready) begin
                  insn  <= mem_rdata;
                  state <= S_EXEC;
               end
            end
            S_EXEC: begin
               state <= (is_load | is_store) ? S_MEM : S_WB;
            end
            S_MEM: begin
               if (mem_ready) begin
                  // A store wins when both flags are set, so mdr is left alone.
                  if (is_load && !is_store) mdr <= mem_rdata;
                  byte_off <= alu_val[1:0];
                  state    <= S_WB;
               end
            end
            S_WB: begin
               pc <= pc_next;
               if (rd_we && (rd != '0)) regs[rd] <= rd_val;
               state <= S_FETCH;
            end
            default: state <= S_FETCH;
         endcase
      end
   end

   // Gated by reset_n so a mid-access reset drops the request immediately.
   assign mem_req   = reset_n & ((state == S_FETCH) | (state == S_MEM));
   assign mem_we    = reset_n & (state == S_MEM) & is_store;
   assign retire    = reset_n & (state == S_WB);
   assign mem_addr  = (state == S_MEM) ? alu_val : pc;
   assign mem_wdata = rs2_val;
   assign insn_out  = insn;
   assign dbg_rdata = (dbg_raddr == '0) ? '0 : regs[dbg_raddr];

endmodule

// File: tb/tb_dataflow_mc.sv
module tb_dataflow_mc;

   logic        clk;
   logic        reset_n;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic        mem_ready;
   logic [31:0] insn_out;
   logic [4:0]  rs1, rs2, rd;
   logic [31:0] imm;
   logic [2:0]  func;
   logic        sub_sra, alu_sel_a, alu_sel_b, pc_alu_sel, pc_next_sel;
   logic [1:0]  rd_sel;
   logic        rd_we, is_load, is_store;
   logic [2:0]  mem_size;
   logic        EQ, LS, LU, retire;
   logic [4:0]  dbg_raddr;
   logic [31:0] dbg_rdata;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] exp_pc;

   dataflow_mc dut (
      .clk(clk), .reset_n(reset_n),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready), .insn_out(insn_out),
      .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm), .func(func), .sub_sra(sub_sra),
      .alu_sel_a(alu_sel_a), .alu_sel_b(alu_sel_b), .pc_alu_sel(pc_alu_sel),
      .pc_next_sel(pc_next_sel), .rd_sel(rd_sel), .rd_we(rd_we), .is_load(is_load),
      .is_store(is_store), .mem_size(mem_size), .EQ(EQ), .LS(LS), .LU(LU),
      .retire(retire), .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  f;
      logic        s;
      logic        a;
      logic        b;
      logic [4:0]  r1;
      logic [4:0]  r2;
      logic [4:0]  rdi;
      logic [31:0] im;
      logic [1:0]  rsel;
      logic        prel;
      logic [31:0] exp;
   } alu_vec_t;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_ctrl();
      rs1 = 0; rs2 = 0; rd = 0; imm = 0; func = 0; sub_sra = 0;
      alu_sel_a = 0; alu_sel_b = 0; pc_alu_sel = 0; pc_next_sel = 0;
      rd_sel = 0; rd_we = 0; is_load = 0; is_store = 0; mem_size = 3'b010;
   endtask

   // Plays memory for one instruction starting in FETCH; returns observations only.
   task automatic run_insn(input logic [31:0] fword, input logic [31:0] dword,
                           input int fwait, input int mwait,
                           output int ret_cyc, output int mreq_cyc,
                           output logic [31:0] faddr, output logic [31:0] maddr,
                           output logic mwe, output logic [31:0] mwdata);
      int   phase;
      int   fw;
      int   mw;
      logic done;
      phase = 0; fw = 0; mw = 0; ret_cyc = -1; mreq_cyc = 0;
      faddr = '0; maddr = '0; mwe = 1'b0; mwdata = '0;
      for (int c = 1; c <= 40 && ret_cyc < 0; c++) begin
         mem_ready = 1'b1;
         mem_rdata = 32'h0;
         if (mem_req) begin
            if (phase == 0) begin
               if (fw == 0) faddr = mem_addr;
               mem_rdata = fword;
               mem_ready = (fw >= fwait);
               fw++;
            end else begin
               if (mw == 0) begin
                  maddr = mem_addr; mwe = mem_we; mwdata = mem_wdata;
               end
               mem_rdata = dword;
               mem_ready = (mw >= mwait);
               mw++;
               mreq_cyc++;
            end
         end
         if (retire) ret_cyc = c;
         done = mem_req && mem_ready;
         step();
         if (done) phase = 1;
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      clear_ctrl();
      mem_ready = 1'b1;
      mem_rdata = 32'h0;
      dbg_raddr = 5'd1;
      repeat (2) @(posedge clk);
      #1;
      n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req got=%0b want=0", mem_req); end
      n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we got=%0b want=0", mem_we); end
      n_checks++; if (retire !== 1'b0) begin n_fail++; $display("FAIL reset_retire got=%0b want=0", retire); end
      n_checks++; if (mem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_pc got=%h want=0", mem_addr); end
      n_checks++; if (insn_out !== 32'h0) begin n_fail++; $display("FAIL reset_insn got=%h want=0", insn_out); end
      n_checks++; if (dbg_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_x1 got=%h want=0", dbg_rdata); end
      reset_n = 1'b1;
      #1;
      n_checks++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL release_mem_req got=%0b want=1", mem_req); end
      n_checks++; if (mem_addr !== 32'h0) begin n_fail++; $display("FAIL release_addr got=%h want=0", mem_addr); end
      exp_pc = 32'h0;
   endtask

   task automatic test_addi();
      clear_ctrl();
      imm = 32'd5; alu_sel_b = 1; rd_sel = 2'b10; rd_we = 1; rd = 5'd1;
      dbg_raddr = 5'd1;
      mem_ready = 1'b1;
      mem_rdata = 32'h00500093;
      step();
      n_checks++; if (insn_out !== 32'h00500093) begin n_fail++; $display("FAIL addi_insn got=%h want=00500093", insn_out); end
      n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL addi_exec_req got=%0b want=0", mem_req); end
      n_checks++; if (retire !== 1'b0) begin n_fail++; $display("FAIL addi_c2_retire got=%0b want=0", retire); end
      step();
      n_checks++; if (retire !== 1'b1) begin n_fail++; $display("FAIL addi_c3_retire got=%0b want=1", retire); end
      n_checks++; if (dbg_rdata !== 32'h0) begin n_fail++; $display("FAIL addi_x1_early got=%h want=0", dbg_rdata); end
      step();
      n_checks++; if (retire !== 1'b0) begin n_fail++; $display("FAIL addi_retire_pulse got=%0b want=0", retire); end
      n_checks++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL addi_next_req got=%0b want=1", mem_req); end
      n_checks++; if (mem_addr !== 32'h4) begin n_fail++; $display("FAIL addi_pc got=%h want=4", mem_addr); end
      n_checks++; if (dbg_rdata !== 32'h5) begin n_fail++; $display("FAIL addi_x1 got=%h want=5", dbg_rdata); end
      exp_pc = 32'h4;
   endtask

   task automatic test_lw_wait();
      int r, mq; logic [31:0] fa, ma, wd; logic we;
      clear_ctrl();
      is_load = 1; alu_sel_b = 1; imm = 32'h40; rd = 5'd2; rd_sel = 2'b00; rd_we = 1;
      mem_size = 3'b010;
      run_insn(32'h04002103, 32'hDEADBEEF, 0, 2, r, mq, fa, ma, we, wd);
      dbg_raddr = 5'd2; #1;
      n_checks++; if (r !== 6) begin n_fail++; $display("FAIL lw_retire_cycle got=%0d want=6", r); end
      n_checks++; if (mq !== 3) begin n_fail++; $display("FAIL lw_req_cycles got=%0d want=3", mq); end
      n_checks++; if (fa !== exp_pc) begin n_fail++; $display("FAIL lw_fetch_addr got=%h want=%h", fa, exp_pc); end
      n_checks++; if (ma !== 32'h40) begin n_fail++; $display("FAIL lw_mem_addr got=%h want=40", ma); end
      n_checks++; if (we !== 1'b0) begin n_fail++; $display("FAIL lw_mem_we got=%0b want=0", we); end
      n_checks++; if (dbg_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL lw_x2 got=%h want=deadbeef", dbg_rdata); end
      exp_pc = exp_pc + 4;
   endtask

   task automatic test_byte_loads();
      logic [2:0]  sz [6] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b000, 3'b011};
      logic [31:0] ad [6] = '{32'h203, 32'h203, 32'h202, 32'h202, 32'h201, 32'h201};
      logic [4:0]  rg [6] = '{5'd3, 5'd4, 5'd3, 5'd4, 5'd5, 5'd6};
      logic [31:0] ex [6] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8012,
                              32'h00008012, 32'h00000034, 32'h80123456};
      int          fwt [6] = '{0, 2, 0, 1, 0, 0};
      int r, mq; logic [31:0] fa, ma, wd; logic we;
      for (int i = 0; i < 6; i++) begin
         clear_ctrl();
         is_load = 1; alu_sel_b = 1; imm = ad[i]; rd = rg[i]; rd_we = 1; mem_size = sz[i];
         run_insn(32'h00000003, 32'h80123456, fwt[i], 0, r, mq, fa, ma, we, wd);
         dbg_raddr = rg[i]; #1;
         n_checks++; if (dbg_rdata !== ex[i]) begin n_fail++; $display("FAIL load%0d_value got=%h want=%h", i, dbg_rdata, ex[i]); end
         n_checks++; if (r !== 4 + fwt[i]) begin n_fail++; $display("FAIL load%0d_retire got=%0d want=%0d", i, r, 4 + fwt[i]); end
         n_checks++; if (fa !== exp_pc) begin n_fail++; $display("FAIL load%0d_fetch_addr got=%h want=%h", i, fa, exp_pc); end
         n_checks++; if (ma !== ad[i]) begin n_fail++; $display("FAIL load%0d_mem_addr got=%h want=%h", i, ma, ad[i]); end
         exp_pc = exp_pc + 4;
      end
   endtask

   task automatic test_alu();
      alu_vec_t tv [16];
      logic [31:0] want;
      int r, mq; logic [31:0] fa, ma, wd; logic we;
      tv[0]  = '{3'd0, 1'b1, 1'b0, 1'b0, 5'd1, 5'd2, 5'd10, 32'h0, 2'b10, 1'b0, 32'h21524116};
      tv[1]  = '{3'd1, 1'b0, 1'b0, 1'b0, 5'd1, 5'd2, 5'd11, 32'h0, 2'b10, 1'b0, 32'h00028000};
      tv[2]  = '{3'd2, 1'b0, 1'b0, 1'b0, 5'd1, 5'd2, 5'd12, 32'h0, 2'b10, 1'b0, 32'h0};
      tv[3]  = '{3'd3, 1'b0, 1'b0, 1'b0, 5'd1, 5'd2, 5'd13, 32'h0, 2'b10, 1'b0, 32'h1};
      tv[4]  = '{3'd4, 1'b0, 1'b0, 1'b0, 5'd1, 5'd2, 5'd14, 32'h0, 2'b10, 1'b0, 32'hDEADBEEA};
      tv[5]  = '{3'd5, 1'b0, 1'b0, 1'b0, 5'd2, 5'd1, 5'd15, 32'h0, 2'b10, 1'b0, 32'h06F56DF7};
      tv[6]  = '{3'd5, 1'b1, 1'b0, 1'b0, 5'd2, 5'd1, 5'd16, 32'h0, 2'b10, 1'b0, 32'hFEF56DF7};
      tv[7]  = '{3'd6, 1'b0, 1'b0, 1'b1, 5'd1, 5'd0, 5'd17, 32'hF0, 2'b10, 1'b0, 32'hF5};
      tv[8]  = '{3'd7, 1'b0, 1'b0, 1'b1, 5'd2, 5'd0, 5'd18, 32'hFF0, 2'b10, 1'b0, 32'hEE0};
      tv[9]  = '{3'd0, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd9, 32'h3, 2'b10, 1'b0, 32'h3};
      tv[10] = '{3'd0, 1'b0, 1'b0, 1'b0, 5'd9, 5'd9, 5'd10, 32'h0, 2'b10, 1'b0, 32'h6};
      tv[11] = '{3'd0, 1'b0, 1'b1, 1'b1, 5'd0, 5'd0, 5'd19, 32'h1000, 2'b10, 1'b1, 32'h1000};
      tv[12] = '{3'd0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd20, 32'h12345000, 2'b01, 1'b0, 32'h12345000};
      tv[13] = '{3'd3, 1'b0, 1'b0, 1'b1, 5'd1, 5'd0, 5'd21, 32'hFFFFFFFF, 2'b10, 1'b0, 32'h1};
      tv[14] = '{3'd2, 1'b0, 1'b0, 1'b1, 5'd1, 5'd0, 5'd22, 32'hFFFFFFFF, 2'b10, 1'b0, 32'h0};
      tv[15] = '{3'd0, 1'b0, 1'b0, 1'b1, 5'd2, 5'd0, 5'd23, 32'h21524111, 2'b10, 1'b0, 32'h0};
      for (int i = 0; i < 16; i++) begin
         clear_ctrl();
         func = tv[i].f; sub_sra = tv[i].s; alu_sel_a = tv[i].a; alu_sel_b = tv[i].b;
         rs1 = tv[i].r1; rs2 = tv[i].r2; rd = tv[i].rdi; imm = tv[i].im;
         rd_sel = tv[i].rsel; rd_we = 1;
         want = tv[i].prel ? tv[i].exp + exp_pc : tv[i].exp;
         run_insn(32'h00000033, 32'h0, 0, 0, r, mq, fa, ma, we, wd);
         dbg_raddr = tv[i].rdi; #1;
         n_checks++; if (dbg_rdata !== want) begin n_fail++; $display("FAIL alu%0d_value got=%h want=%h", i, dbg_rdata, want); end
         n_checks++; if (r !== 3) begin n_fail++; $display("FAIL alu%0d_retire got=%0d want=3", i, r); end
         n_checks++; if (fa !== exp_pc) begin n_fail++; $display("FAIL alu%0d_fetch_addr got=%h want=%h", i, fa, exp_pc); end
         exp_pc = exp_pc + 4;
      end
   endtask

   task automatic test_compare();
      clear_ctrl();
      mem_ready = 1'b0;
      rs1 = 5'd1; rs2 = 5'd2; #1;
      n_checks++; if ({EQ, LS, LU} !== 3'b001) begin n_fail++; $display("FAIL cmp_5_vs_neg got=%b want=001", {EQ, LS, LU}); end
      rs1 = 5'd2; rs2 = 5'd1; #1;
      n_checks++; if ({EQ, LS, LU} !== 3'b010) begin n_fail++; $display("FAIL cmp_neg_vs_5 got=%b want=010", {EQ, LS, LU}); end
      rs1 = 5'd2; rs2 = 5'd2; #1;
      n_checks++; if ({EQ, LS, LU} !== 3'b100) begin n_fail++; $display("FAIL cmp_equal got=%b want=100", {EQ, LS, LU}); end
      rs1 = 5'd1; alu_sel_b = 1; imm = 32'd5; #1;
      n_checks++; if ({EQ, LS, LU} !== 3'b100) begin n_fail++; $display("FAIL cmp_imm_equal got=%b want=100", {EQ, LS, LU}); end
      clear_ctrl();
      mem_ready = 1'b1;
   endtask

   task automatic test_branch_x0();
      int r, mq; logic [31:0] fa, ma, wd; logic we;
      logic [31:0] link;
      clear_ctrl();
      pc_next_sel = 1; alu_sel_b = 1; imm = 32'h101; rd = 5'd5; rd_sel = 2'b11; rd_we = 1;
      link = exp_pc + 4;
      run_insn(32'h101002E7, 32'h0, 0, 0, r, mq, fa, ma, we, wd);
      dbg_raddr = 5'd5; #1;
      n_checks++; if (dbg_rdata !== link) begin n_fail++; $display("FAIL jalr_link got=%h want=%h", dbg_rdata, link); end
      n_checks++; if (fa !== exp_pc) begin n_fail++; $display("FAIL jalr_fetch_addr got=%h want=%h", fa, exp_pc); end
      clear_ctrl();
      rs1 = 5'd9; rs2 = 5'd9; pc_alu_sel = 1; imm = 32'hFFFFFFF8; #1;
      n_checks++; if (EQ !== 1'b1) begin n_fail++; $display("FAIL beq_eq got=%0b want=1", EQ); end
      run_insn(32'hFE948CE3, 32'h0, 0, 0, r, mq, fa, ma, we, wd);
      n_checks++; if (fa !== 32'h100) begin n_fail++; $display("FAIL jalr_target got=%h want=100", fa); end
      n_checks++; if (r !== 3) begin n_fail++; $display("FAIL beq_retire got=%0d want=3", r); end
      clear_ctrl();
      rd = 5'd0; rd_sel = 2'b01; imm = 32'd7; rd_we = 1;
      run_insn(32'h00700013, 32'h0, 0, 0, r, mq, fa, ma, we, wd);
      dbg_raddr = 5'd0; #1;
      n_checks++; if (fa !== 32'hF8) begin n_fail++; $display("FAIL beq_target got=%h want=f8", fa); end
      n_checks++; if (dbg_rdata !== 32'h0) begin n_fail++; $display("FAIL x0_write got=%h want=0", dbg_rdata); end
      exp_pc = 32'hFC;
   endtask

   task automatic test_store();
      int r, mq; logic [31:0] fa, ma, wd; logic we;
      clear_ctrl();
      is_store = 1; is_load = 1; alu_sel_b = 1; imm = 32'h300; rs2 = 5'd2;
      run_insn(32'h30202023, 32'h11111111, 0, 0, r, mq, fa, ma, we, wd);
      n_checks++; if (r !== 4) begin n_fail++; $display("FAIL sw_retire got=%0d want=4", r); end
      n_checks++; if (fa !== exp_pc) begin n_fail++; $display("FAIL sw_fetch_addr got=%h want=%h", fa, exp_pc); end
      n_checks++; if (ma !== 32'h300) begin n_fail++; $display("FAIL sw_mem_addr got=%h want=300", ma); end
      n_checks++; if (we !== 1'b1) begin n_fail++; $display("FAIL sw_mem_we got=%0b want=1", we); end
      n_checks++; if (wd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL sw_wdata got=%h want=deadbeef", wd); end
      exp_pc = exp_pc + 4;
      // mdr must still hold the last load, not the data seen during the store
      clear_ctrl();
      rd = 5'd24; rd_sel = 2'b00; rd_we = 1; mem_size = 3'b010;
      run_insn(32'h00000033, 32'h0, 0, 0, r, mq, fa, ma, we, wd);
      dbg_raddr = 5'd24; #1;
      n_checks++; if (dbg_rdata !== 32'h80123456) begin n_fail++; $display("FAIL sw_mdr_kept got=%h want=80123456", dbg_rdata); end
      n_checks++; if (r !== 3) begin n_fail++; $display("FAIL mdr_read_retire got=%0d want=3", r); end
      exp_pc = exp_pc + 4;
   endtask

   task automatic test_reset_mid_store();
      int r, mq; logic [31:0] fa, ma, wd; logic we;
      clear_ctrl();
      is_store = 1; alu_sel_b = 1; imm = 32'h304; rs2 = 5'd2; rd = 5'd13; rd_sel = 2'b01; rd_we = 1;
      mem_ready = 1'b1; mem_rdata = 32'h30202223;
      n_checks++; if (mem_addr !== exp_pc) begin n_fail++; $display("FAIL rst_store_fetch_addr got=%h want=%h", mem_addr, exp_pc); end
      step();
      step();
      mem_ready = 1'b0;
      n_checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1) begin n_fail++; $display("FAIL rst_store_in_mem got=%0b%0b want=11", mem_req, mem_we); end
      n_checks++; if (mem_addr !== 32'h304) begin n_fail++; $display("FAIL rst_store_addr got=%h want=304", mem_addr); end
      #1 reset_n = 1'b0;
      #1;
      n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL rst_abort_req got=%0b want=0", mem_req); end
      n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL rst_abort_we got=%0b want=0", mem_we); end
      mem_ready = 1'b1;
      repeat (2) step();
      n_checks++; if (retire !== 1'b0) begin n_fail++; $display("FAIL rst_hold_retire got=%0b want=0", retire); end
      reset_n = 1'b1;
      dbg_raddr = 5'd2;
      #1;
      n_checks++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL rst_release_req got=%0b want=1", mem_req); end
      n_checks++; if (mem_addr !== 32'h0) begin n_fail++; $display("FAIL rst_release_pc got=%h want=0", mem_addr); end
      n_checks++; if (dbg_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_regs_clear got=%h want=0", dbg_rdata); end
      clear_ctrl();
      imm = 32'd9; alu_sel_b = 1; rd = 5'd7; rd_sel = 2'b10; rd_we = 1;
      run_insn(32'h00900393, 32'h0, 0, 0, r, mq, fa, ma, we, wd);
      dbg_raddr = 5'd7; #1;
      n_checks++; if (fa !== 32'h0) begin n_fail++; $display("FAIL post_rst_fetch got=%h want=0", fa); end
      n_checks++; if (r !== 3) begin n_fail++; $display("FAIL post_rst_retire got=%0d want=3", r); end
      n_checks++; if (dbg_rdata !== 32'h9) begin n_fail++; $display("FAIL post_rst_x7 got=%h want=9", dbg_rdata); end
   endtask

   initial begin
      test_reset();
      test_addi();
      test_lw_wait();
      test_byte_loads();
      test_alu();
      test_compare();
      test_branch_x0();
      test_store();
      test_reset_mid_store();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
